// File: rtl/my_xor_checksum_if.sv
// Stream interface for the XOR checksum block: input word channel and
// result channel, each with its own valid/ready handshake.
interface my_xor_checksum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    // Producer of words / consumer of results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_parity, out_count, out_ovf
    );

    // The checksum block itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_parity, out_count, out_ovf
    );
endinterface

// File: rtl/my_xor_checksum.sv
// Streaming XOR checksum: folds every word of a frame into a WIDTH-bit
// accumulator, counts words with saturation, and presents sum, parity,
// count and overflow once per frame until the consumer takes them.
module my_xor_checksum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    my_xor_checksum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_parity_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;
    logic             accept;

    // in_ready is a register, so accept never depends combinationally on out_ready.
    assign accept = bus.in_valid & in_ready_q;

    // Accumulator/counter value after folding in the current input word.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output first so no latch is inferred.
        acc_d = acc_q ^ bus.in_data;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == IDLE) begin
            acc_d = bus.in_data;
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            // Saturate rather than wrap; remember that words were lost from the count.
            ovf_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Frame FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (bus.in_last) begin
                            state_q      <= HOLD;
                            in_ready_q   <= 1'b0;
                            out_valid_q  <= 1'b1;
                            out_sum_q    <= acc_d;
                            out_parity_q <= ^acc_d;
                            out_count_q  <= cnt_d;
                            out_ovf_q    <= ovf_d;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                HOLD: begin
                    // Result fields keep their values after release; only out_valid drops.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_ovf    = out_ovf_q;
endmodule

// File: tb/tb_my_xor_checksum.sv
// Directed bench for my_xor_checksum: table of frames plus hand-written
// sequences for reset abort, backpressure, gaps and counter saturation.
module tb_my_xor_checksum;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    my_xor_checksum_if #(.WIDTH(8), .CNT_W(8)) a ();
    my_xor_checksum_if #(.WIDTH(8), .CNT_W(2)) b ();

    my_xor_checksum #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    my_xor_checksum #(.WIDTH(8), .CNT_W(2)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] w;     // w[0] is sent first
        int              n;
        logic [7:0]      sum;
        logic            par;
        logic [7:0]      cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Present one word on DUT a and wait (bounded) until it is accepted.
    // Called and returns at #1 after a rising edge.
    task automatic drive_word(input logic [7:0] d, input logic last);
        int cycles;
        a.in_valid = 1'b1;
        a.in_data  = d;
        a.in_last  = last;
        cycles = 0;
        while (!a.in_ready && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!a.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stuck at %0b for word %0h", a.in_ready, d);
        end
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        a.in_last  = 1'b0;
    endtask

    // Check the held result on DUT a right after the last accept.
    task automatic check_result(input string tag, input logic [7:0] sum, input logic par,
                                input logic [7:0] cnt, input logic ovf);
        check({tag, ".valid"},  32'(a.out_valid),  32'(1'b1));
        check({tag, ".ready"},  32'(a.in_ready),   32'(1'b0));
        check({tag, ".sum"},    32'(a.out_sum),    32'(sum));
        check({tag, ".parity"}, 32'(a.out_parity), 32'(par));
        check({tag, ".count"},  32'(a.out_count),  32'(cnt));
        check({tag, ".ovf"},    32'(a.out_ovf),    32'(ovf));
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        for (int i = 0; i < v.n; i++) begin
            drive_word(v.w[i], i == v.n - 1);
            if (i != v.n - 1)
                check({tag, ".early_valid"}, 32'(a.out_valid), 32'(1'b0));
        end
        check_result(tag, v.sum, v.par, v.cnt, 1'b0);
        // out_ready is high, so the result is taken on the next edge.
        @(posedge clk); #1;
        check({tag, ".released"},  32'(a.out_valid), 32'(1'b0));
        check({tag, ".ready_back"}, 32'(a.in_ready), 32'(1'b1));
        check({tag, ".sum_kept"},  32'(a.out_sum),   32'(v.sum));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.out_ready = 1'b1;

        vecs[0] = '{w: {8'h00, 8'h3C, 8'hF0, 8'h0F}, n: 3, sum: 8'hC3, par: 1'b0, cnt: 8'd3};
        vecs[1] = '{w: {8'h00, 8'h00, 8'h00, 8'h07}, n: 1, sum: 8'h07, par: 1'b1, cnt: 8'd1};
        vecs[2] = '{w: {8'h00, 8'h00, 8'h00, 8'h00}, n: 2, sum: 8'h00, par: 1'b0, cnt: 8'd2};
        vecs[3] = '{w: {8'h00, 8'h56, 8'h34, 8'h12}, n: 3, sum: 8'h70, par: 1'b1, cnt: 8'd3};
        vecs[4] = '{w: {8'h10, 8'h01, 8'h0F, 8'hFF}, n: 4, sum: 8'hE1, par: 1'b0, cnt: 8'd4};

        // Reset values
        #12;
        check("rst.in_ready",  32'(a.in_ready),   32'(1'b1));
        check("rst.out_valid", 32'(a.out_valid),  32'(1'b0));
        check("rst.out_sum",   32'(a.out_sum),    32'(8'h00));
        check("rst.out_par",   32'(a.out_parity), 32'(1'b0));
        check("rst.out_count", 32'(a.out_count),  32'(8'd0));
        check("rst.out_ovf",   32'(a.out_ovf),    32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames with out_ready held high
        for (int i = 0; i < 5; i++)
            run_frame(i, vecs[i]);

        // Reset mid-frame after 3 words, then a single-word frame
        drive_word(8'h11, 1'b0);
        drive_word(8'h22, 1'b0);
        drive_word(8'h33, 1'b0);
        check("abort.no_valid", 32'(a.out_valid), 32'(1'b0));
        rst_n = 1'b0;
        #2;
        check("abort.out_valid", 32'(a.out_valid), 32'(1'b0));
        check("abort.in_ready",  32'(a.in_ready),  32'(1'b1));
        check("abort.out_count", 32'(a.out_count), 32'(8'd0));
        check("abort.out_sum",   32'(a.out_sum),   32'(8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort.still_quiet", 32'(a.out_valid), 32'(1'b0));
        drive_word(8'hA5, 1'b1);
        check_result("after_abort", 8'hA5, 1'b0, 8'd1, 1'b0);
        @(posedge clk); #1;

        // Backpressure: result must hold while 8'hFF waits on the input
        a.out_ready = 1'b0;
        drive_word(8'h01, 1'b0);
        drive_word(8'h02, 1'b1);
        a.in_valid = 1'b1;
        a.in_data  = 8'hFF;
        a.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_result($sformatf("bp%0d", c), 8'h03, 1'b0, 8'd2, 1'b0);
            @(posedge clk); #1;
        end
        a.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.released",  32'(a.out_valid), 32'(1'b0));
        check("bp.ready_back", 32'(a.in_ready), 32'(1'b1));
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        a.in_last  = 1'b0;
        check_result("bp_ff", 8'hFF, 1'b0, 8'd1, 1'b0);
        @(posedge clk); #1;
        check("bp_ff.released", 32'(a.out_valid), 32'(1'b0));

        // Gaps between words keep the accumulator
        drive_word(8'h80, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("gap%0d.valid", c), 32'(a.out_valid), 32'(1'b0));
            check($sformatf("gap%0d.ready", c), 32'(a.in_ready),  32'(1'b1));
        end
        drive_word(8'h01, 1'b1);
        check_result("gaps", 8'h81, 1'b0, 8'd2, 1'b0);
        @(posedge clk); #1;

        // Saturation on the CNT_W=2 instance: 5 words of 8'h11
        b.in_valid = 1'b1;
        b.in_data  = 8'h11;
        b.in_last  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("ovf.ready%0d", c), 32'(b.in_ready), 32'(1'b1));
            @(posedge clk); #1;
        end
        b.in_last = 1'b1;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        check("ovf.valid", 32'(b.out_valid), 32'(1'b1));
        check("ovf.count", 32'(b.out_count), 32'(2'd3));
        check("ovf.flag",  32'(b.out_ovf),   32'(1'b1));
        check("ovf.sum",   32'(b.out_sum),   32'(8'h11));
        check("ovf.par",   32'(b.out_parity), 32'(1'b0));
        @(posedge clk); #1;
        check("ovf.released", 32'(b.out_valid), 32'(1'b0));

        // Exactly 2^CNT_W-1 words: full count, no overflow
        b.in_valid = 1'b1;
        b.in_data  = 8'h11;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
        end
        b.in_last = 1'b1;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        check("max.valid", 32'(b.out_valid), 32'(1'b1));
        check("max.count", 32'(b.out_count), 32'(2'd3));
        check("max.flag",  32'(b.out_ovf),   32'(1'b0));
        check("max.sum",   32'(b.out_sum),   32'(8'h11));
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/my_xor_checksum.md
Name: my_xor_checksum

Overview:
- Parametrised successor of the 2-input XOR gate: streaming XOR-reduction (checksum plus parity) over frames of WIDTH-bit words.
- Valid/ready handshake on both input and output.
- Word counter with overflow flag.
- Serves as the parity/checksum stage for later datapath labs; the first sequential block in the basic-gates series.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- CNT_W, 8, word-counter width; max countable frame = 2^CNT_W − 1 words.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  data word
- in_last  input  1  marks final word of frame
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  WIDTH  bitwise XOR of all frame words
- out_parity  output  1  XOR of all bits of out_sum (1 = odd number of ones in frame)
- out_count  output  CNT_W  number of words in frame (saturating)
- out_ovf  output  1  frame exceeded 2^CNT_W − 1 words

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n); all state updates on rising edge of clk.
- Reset values: state = IDLE, accumulator = 0, count = 0, ovf = 0, out_valid = 0, out_sum = 0, out_parity = 0, out_count = 0, out_ovf = 0. in_ready = 1 out of reset.
- Reset mid-frame or mid-HOLD: immediate abort, same values as above; partial frame discarded, no result emitted.
- Accept condition: in_valid & in_ready at a rising edge.
- States:
  - IDLE: no frame in progress. On accept: acc <= in_data, count <= 1, ovf <= 0. If in_last is also set, go to HOLD, else go to ACC.
  - ACC: on accept, acc <= acc ^ in_data and count increments. At 2^CNT_W − 1 the count holds and ovf is set. On accept with in_last, go to HOLD. No accept means no change.
  - HOLD: in_ready = 0; input ignored regardless of in_valid.
- Output capture on entering HOLD: out_sum = final acc including the last word, out_parity = ^out_sum, out_count = final count, out_ovf = final ovf, out_valid = 1.
- Latency: the last word is accepted at edge k; out_valid and the result are visible after edge k (one cycle).
- Holding and release:
  - out_valid and the result stay stable until out_valid & out_ready at an edge.
  - On that edge: out_valid <= 0, state <= IDLE, in_ready = 1 from the next cycle. There is no same-cycle pass-through from out_ready to in_ready.
  - out_sum, out_parity and out_count keep their last values after release; only out_valid qualifies them.
- in_ready is a registered/state-decoded signal: 1 in IDLE and ACC, 0 in HOLD.
- Width rules: XOR is bitwise over WIDTH bits, no carry. Count is unsigned CNT_W, saturating, never wraps to 0.
- Boundary conditions:
  - Single-word frame (IDLE accept with in_last): out_sum = that word, out_count = 1.
  - Zero-valued words are still counted.
  - out_ready high while out_valid is low has no effect.
  - in_valid low between words of a frame inserts gaps; the accumulator is held.

Test Plan:
- Reset: assert rst_n = 0 mid-ACC after 3 words, release, then send single word 8'hA5 with last. Required: out_sum = A5, out_parity = 0, out_count = 1, out_ovf = 0; no output from the aborted frame.
- Multi-word frame 8'h0F, 8'hF0, 8'h3C (last), out_ready = 1. Required: out_valid one cycle after the last accept; out_sum = C3, out_parity = 0, out_count = 3; in_ready back to 1 two cycles after the last accept.
- Backpressure: frame 8'h01, 8'h02 (last) with out_ready = 0 for 5 cycles, and in_valid held high with 8'hFF. Required: out_sum = 03, parity = 0, count = 2 stable for all 5 cycles; in_ready = 0; 8'hFF not accepted until after release.
- Gaps: frame 8'h80, idle 3 cycles, 8'h01 (last). Required: out_sum = 81, out_parity = 0, out_count = 2.
- Parity: frame 8'h07 (last). Required: out_sum = 07, out_parity = 1.
- Overflow (CNT_W = 2): 5 words of 8'h11, last on word 5. Required: out_count = 3 (saturated), out_ovf = 1, out_sum = 11.
